lbc_byte_encoder: RTL and testbench
===================================

Name: lbc_byte_encoder

Overview:
- Systematic (14,8) linear block code encoder for a byte stream.
- Each clock samples one data byte from the low byte of a 32-bit input bus and registers its 6-bit parity word.
- Keeps the four most recent data bytes in a byte-wide delay line, exposed as four outputs.
- Provides a divide-by-4 frame clock, used to align 4-byte frames at system level and for debug probing.

Parameters:
- None. Widths are fixed: data byte 8, parity 6, delay depth 4, frame divide 4.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- Din  in  32  input word; only Din[7:0] is encoded, Din[31:8] reserved and ignored.
- Qout1  out  8  most recent registered data byte.
- Qout2  out  8  data byte delayed one further cycle.
- Qout3  out  8  data byte delayed two further cycles.
- Qout4  out  8  oldest data byte, delayed three further cycles.
- clk_test  out  1  frame clock, clk/4, registered.
- C  out  6  parity word of the byte currently on Qout1.

Behaviour:
- Reset: clk and reset are as already decided (one clock; reset is asynchronous and active-low). rst_n=0 forces Qout1..Qout4=8'h00, C=6'h00, clk_test=0 and frame counter=0, regardless of clk.
- After rst_n deasserts, operation starts on the first rising edge.
- Shift on every rising edge, with no enable:
  - Qout1<=Din[7:0]
  - Qout2<=Qout1
  - Qout3<=Qout2
  - Qout4<=Qout3
- Latency: Din sampled at edge N appears on Qout1 after edge N, on Qout4 after edge N+3.
- Parity: C is registered on the same edge as Qout1, so C always corresponds to Qout1 (1-cycle latency). With d=Din[7:0]:
  - C[0]=d0^d1^d3^d4^d6
  - C[1]=d0^d2^d3^d5^d6
  - C[2]=d1^d2^d3^d7
  - C[3]=d4^d5^d6^d7
  - C[4]=^d[7:0] (overall data parity)
  - C[5]=d1^d3^d5^d7
- Codeword: {C, Qout1} is the 14-bit systematic codeword.
- The code is linear: C(a^b)=C(a)^C(b), and C(0)=0.
- Frame counter: 2-bit free-running, increments every edge and wraps 3->0. clk_test=counter[1], registered. Period 4 clk, 50% duty, low for the 2 cycles after reset.
- Din[31:8] has no effect on any output.
- Reset asserted mid-stream clears all state immediately. After release, the counter restarts at 0.
- No handshake; a new byte is accepted every cycle.

Decomposition:
- Shared package lbc_pkg holds:
  - DATA_W=8, PAR_W=6, DEPTH=4.
  - Six 8-bit parity masks P_MASK[0..5] = 8'h5B, 8'h6D, 8'h8E, 8'hF0, 8'hFF, 8'hAA.
  - Codeword typedef (14 bits).
- C[k] = ^(d & P_MASK[k]).
- One combinational sub-module lbc_parity_gen (8-bit in, 6-bit out) computes the parity; the top registers its output.

Test Plan:
- Reset: hold rst_n=0 with Din toggling -> all Q outputs 8'h00, C=0, clk_test=0. Assert rst_n mid-stream -> outputs clear asynchronously, before the next edge.
- Single byte: Din=32'h01 for one cycle, then 0 -> after that edge Qout1=8'h01 and C=6'h13. One cycle later Qout2=8'h01, Qout1=0, C=0. Qout4=8'h01 three cycles after it first appears on Qout1.
- Parity vectors:
  - Din=8'hFF -> C=6'h03
  - Din=8'h80 -> C=6'h3C
  - Din=8'h00 -> C=6'h00
  - Din=32'hABCD_EF01 -> C=6'h13 (upper bits ignored)
- Sweep: i=1..255, each byte followed by three zero bytes -> C matches the mask equations for every i. Each byte walks Qout1->Qout4 on consecutive cycles; the delay line is never occupied by two non-zero bytes at once.
- Frame clock: free-run 16 cycles after reset -> clk_test pattern 0,0,1,1 repeating, exactly 4 rising edges of clk_test.
- Linearity: random a,b -> C(a^b)==C(a)^C(b), checked over 1000 random pairs.

Source files
------------

// File: rtl/lbc_pkg.sv
// lbc_pkg: shared widths, parity masks and codeword type for the (14,8) byte encoder
package lbc_pkg;
    localparam int DATA_W = 8;
    localparam int PAR_W  = 6;
    localparam int DEPTH  = 4;
    localparam logic [DATA_W-1:0] P_MASK [PAR_W] = '{8'h5B, 8'h6D, 8'h8E, 8'hF0, 8'hFF, 8'hAA};
    typedef logic [PAR_W+DATA_W-1:0] codeword_t;
endpackage

// File: rtl/lbc_parity_gen.sv
// lbc_parity_gen: combinational parity word; i_data data byte in, o_par 6-bit parity out
module lbc_parity_gen
    import lbc_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [PAR_W-1:0]  o_par
);
    for (genvar k = 0; k < PAR_W; k++) begin : g_par
        assign o_par[k] = ^(i_data & P_MASK[k]);
    end
endmodule

// File: rtl/lbc_byte_encoder.sv
// lbc_byte_encoder: (14,8) systematic encoder with 4-deep byte delay line and clk/4 frame clock
// Ports: clk, rst_n (async low); Din (low byte encoded); Qout1..Qout4 delay line taps; C parity of Qout1; clk_test frame clock
module lbc_byte_encoder
    import lbc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        Din,
    output logic [DATA_W-1:0]  Qout1,
    output logic [DATA_W-1:0]  Qout2,
    output logic [DATA_W-1:0]  Qout3,
    output logic [DATA_W-1:0]  Qout4,
    output logic               clk_test,
    output logic [PAR_W-1:0]   C
);
    logic [DATA_W-1:0] r_q [DEPTH];
    logic [PAR_W-1:0]  r_c;
    logic [PAR_W-1:0]  w_par;
    logic [1:0]        r_cnt;
    lbc_parity_gen u_par (
        .i_data (Din[DATA_W-1:0]),
        .o_par  (w_par)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '{default: '0};
            r_c   <= '0;
            r_cnt <= '0;
        end else begin
            r_q[0] <= Din[DATA_W-1:0];
            for (int i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
            r_c   <= w_par;
            r_cnt <= r_cnt + 2'd1;
        end
    end
    // counter MSB is itself a flop, so the frame clock is glitch-free
    assign clk_test = r_cnt[1];
    assign Qout1    = r_q[0];
    assign Qout2    = r_q[1];
    assign Qout3    = r_q[2];
    assign Qout4    = r_q[3];
    assign C        = r_c;
endmodule

// File: tb/tb_lbc_byte_encoder.sv
// tb_lbc_byte_encoder: self-checking bench for lbc_byte_encoder
module tb_lbc_byte_encoder;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] Din = 0;
    logic [7:0]  Qout1, Qout2, Qout3, Qout4;
    logic        clk_test;
    logic [5:0]  C;
    int checks = 0;
    int failures = 0;
    logic [7:0] m_q [4];
    int m_cyc;

    lbc_byte_encoder dut (
        .clk(clk), .rst_n(rst_n), .Din(Din),
        .Qout1(Qout1), .Qout2(Qout2), .Qout3(Qout3), .Qout4(Qout4),
        .clk_test(clk_test), .C(C)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [5:0]  c;
    } vec_t;
    vec_t vecs [5];

    function automatic logic [5:0] ref_par(input logic [7:0] d);
        return {d[1]^d[3]^d[5]^d[7],
                ^d,
                d[4]^d[5]^d[6]^d[7],
                d[1]^d[2]^d[3]^d[7],
                d[0]^d[2]^d[3]^d[5]^d[6],
                d[0]^d[1]^d[3]^d[4]^d[6]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_q[i] = 8'h00;
        m_cyc = 0;
    endtask

    task automatic step(input logic [31:0] d);
        Din = d;
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) m_q[i] = m_q[i-1];
        m_q[0] = d[7:0];
        m_cyc++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q1"}, 32'(Qout1), 32'(m_q[0]));
        chk({tag, "_q2"}, 32'(Qout2), 32'(m_q[1]));
        chk({tag, "_q3"}, 32'(Qout3), 32'(m_q[2]));
        chk({tag, "_q4"}, 32'(Qout4), 32'(m_q[3]));
        chk({tag, "_c"}, 32'(C), 32'(ref_par(m_q[0])));
        chk({tag, "_ct"}, 32'(clk_test), 32'((m_cyc % 4) >= 2));
    endtask

    initial begin
        logic [31:0] a, b;
        logic [5:0]  ca, cb;
        logic        prev;
        int          rises, nz;
        vecs[0] = '{32'h0000_0001, 6'h13};
        vecs[1] = '{32'h0000_00FF, 6'h03};
        vecs[2] = '{32'h0000_0080, 6'h3C};
        vecs[3] = '{32'h0000_0000, 6'h00};
        vecs[4] = '{32'hABCD_EF01, 6'h13};
        model_reset();
        for (int i = 0; i < 4; i++) begin
            Din = $urandom;
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        @(negedge clk);
        rst_n = 1;
        prev = clk_test;
        rises = 0;
        for (int i = 0; i < 16; i++) begin
            step(32'h0);
            check_all("frame");
            if (clk_test && !prev) rises++;
            prev = clk_test;
        end
        chk("frame_rises", 32'(rises), 32'd4);
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].din);
            chk("tbl_c", 32'(C), 32'(vecs[i].c));
            chk("tbl_q1", 32'(Qout1), 32'(vecs[i].din[7:0]));
            check_all("tbl");
        end
        step(32'h0); step(32'h0); step(32'h0);
        step(32'h1);
        chk("single_q1", 32'(Qout1), 32'h01);
        chk("single_c", 32'(C), 32'h13);
        step(32'h0);
        chk("single_q2", 32'(Qout2), 32'h01);
        chk("single_q1z", 32'(Qout1), 32'h00);
        chk("single_cz", 32'(C), 32'h00);
        step(32'h0);
        step(32'h0);
        chk("single_q4", 32'(Qout4), 32'h01);
        for (int i = 1; i < 256; i++) begin
            for (int j = 0; j < 4; j++) begin
                a = $urandom;
                step(j == 0 ? {a[31:8], 8'(i)} : {a[31:8], 8'h00});
                check_all("sweep");
                nz = 0;
                for (int k = 0; k < 4; k++) if (m_q[k] != 0) nz++;
                chk("sweep_occ", 32'((Qout1 != 0) + (Qout2 != 0) + (Qout3 != 0) + (Qout4 != 0)), 32'(nz));
            end
        end
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            step(a); ca = C;
            check_all("lin_a");
            step(b); cb = C;
            step(a ^ b);
            chk("lin", 32'(C), 32'(ca ^ cb));
        end
        step(32'h5A);
        step(32'hC3);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            step(a);
            check_all("post_rst");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
